vga_rx_monitor: RTL and testbench
=================================

Name: vga_rx_monitor

Overview:
- Receive-side companion to the VGA timing generator: samples hsync/vsync/rgb on the pixel clock and recovers pixel coordinates and pixel data.
- Checks every line and frame against the 640x480@60 timing, locks after one clean frame, and counts timing errors.
- Used as an in-simulation sink/checker for the VGA top and as the front end of a future frame-capture path.

Parameters:
- H_SYNC, 96, hsync pulse width in pixel clocks
- H_BACK, 40, horizontal back porch
- H_LEFT, 8, left border
- H_VALID, 640, active pixels per line
- H_TOTAL, 800, pixel clocks per line
- V_SYNC, 2, vsync pulse width in lines
- V_BACK, 25, vertical back porch
- V_TOP, 8, top border
- V_VALID, 480, active lines
- V_TOTAL, 525, lines per frame

Ports:
- vga_clk  in  1  pixel clock (25 MHz); single clock domain
- sys_rst_n  in  1  reset, asynchronous assert, active-low
- hsync  in  1  line sync, active-high pulse at line start
- vsync  in  1  field sync, active-high, rises together with hsync at frame start
- rgb  in  16  RGB565 pixel data
- pix_x  out  10  recovered x, 0..639
- pix_y  out  10  recovered y, 0..479
- pix_rgb  out  16  captured pixel; 0 when pix_valid=0
- pix_valid  out  1  active-area pixel, asserted only while locked
- frame_start  out  1  one-cycle pulse per frame start while locked
- locked  out  1  timing lock indicator
- err_cnt  out  8  timing error count, saturates at 255
- frame_cnt  out  16  locked frame count, wraps

Behaviour:
- Reset: all outputs 0; state SEARCH; sample registers and previous-sample registers 0.
  - If hsync is high at reset release, the first sample counts as a rising edge.
- Stage 1 registers the inputs as s_hs, s_vs, s_rgb. Stage 2 registers all outputs.
  - Latency is fixed at 2 vga_clk cycles from input pins to pix_* outputs.
- h_pos (11 bit):
  - 0 on the stage-1 sample where s_hs=1 and the previous s_hs=0 (line start).
  - Otherwise h_pos+1, saturating at 2047.
- v_pos (10 bit), updated at line start:
  - 0 if s_vs=1 and the vsync sampled at the previous line start was 0 (frame start).
  - Otherwise v_pos+1, saturating at 1023.
- Active window: h_pos in [144,784) and v_pos in [35,515), i.e. H_SYNC+H_BACK+H_LEFT and V_SYNC+V_BACK+V_TOP offsets.
  - pix_x = h_pos-144, pix_y = v_pos-35, pix_rgb = s_rgb.
  - pix_valid = window AND state==LOCKED. Outside that, pix_x/pix_y hold 0 and pix_rgb = 0.
- Checks, active in LOCKING and LOCKED only:
  - E1: at a line start, the previous h_pos must equal H_TOTAL-1.
  - E2: the first s_hs=0 sample after a line start must have h_pos == H_SYNC.
  - E3: h_pos reaching H_TOTAL without a line start (missing hsync); flagged once per line.
  - E4: at a frame start, the previous v_pos must equal V_TOTAL-1.
  - E5: at each line start, s_vs must equal (v_pos_new < V_SYNC).
- State machine:
  - SEARCH -> LOCKING on a frame start.
  - LOCKING -> LOCKED on the next frame start with no error during that frame; locked=1.
  - LOCKING/LOCKED -> SEARCH on any error; locked=0, err_cnt+1 (saturating). Multiple errors in one cycle count as one.
  - Error and frame start on the same cycle: the error wins, go to SEARCH; that frame start does not re-enter LOCKING.
- frame_start pulses and frame_cnt increments on each frame start that leaves the FSM in LOCKED. This includes the LOCKING->LOCKED transition.
- Reset mid-frame: immediate return to reset values. err_cnt and frame_cnt clear.

Test Plan:
- Nominal 800x525 stream: first frame start enters LOCKING; 420000 cycles later locked=1, frame_start pulse, frame_cnt=1. rgb=16'hF800 at h=144,v=35 appears 2 cycles later as pix_valid=1, pix_x=0, pix_y=0, pix_rgb=16'hF800.
- Active-area edges while locked:
  - h=783, v=514 -> pix_x=639, pix_y=479.
  - h=784 or v=515 -> pix_valid=0, pix_rgb=0.
  - h=143 -> pix_valid=0.
- One 801-cycle line while locked -> locked=0 at the next line start, err_cnt=1; locked=1 again after two clean frame starts.
- hsync width 95 in one line -> E2, locked=0, err_cnt=1. vsync held for 3 lines -> E5, err_cnt increments.
- hsync held low -> E3 at h_pos=800, err_cnt=1 (not incremented again while in SEARCH). Force err_cnt to 255 via repeated errors -> stays 255.
- sys_rst_n pulsed low mid-frame while locked -> all outputs 0 asynchronously; relock after two frame starts with frame_cnt=1.

Source files
------------

// File: rtl/vga_rx_monitor.sv
// vga_rx_monitor: recovers pixel coordinates and data from a sampled VGA stream and checks line/frame timing.
module vga_rx_monitor #(
  parameter int H_SYNC  = 96,
  parameter int H_BACK  = 40,
  parameter int H_LEFT  = 8,
  parameter int H_VALID = 640,
  parameter int H_TOTAL = 800,
  parameter int V_SYNC  = 2,
  parameter int V_BACK  = 25,
  parameter int V_TOP   = 8,
  parameter int V_VALID = 480,
  parameter int V_TOTAL = 525
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [15:0] rgb,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [15:0] pix_rgb,
  output logic        pix_valid,
  output logic        frame_start,
  output logic        locked,
  output logic [7:0]  err_cnt,
  output logic [15:0] frame_cnt
);
  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_END  = 11'(H_TOTAL);
  localparam logic [10:0] H_SW   = 11'(H_SYNC);
  localparam logic [10:0] X0     = 11'(H_SYNC + H_BACK + H_LEFT);
  localparam logic [10:0] X1     = 11'(H_SYNC + H_BACK + H_LEFT + H_VALID);
  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_SW   = 10'(V_SYNC);
  localparam logic [9:0]  Y0     = 10'(V_SYNC + V_BACK + V_TOP);
  localparam logic [9:0]  Y1     = 10'(V_SYNC + V_BACK + V_TOP + V_VALID);

  typedef enum logic [1:0] {SEARCH, LOCKING, LOCKED} state_t;
  state_t state, nxt;
  logic s_hs, s_vs, p_hs, vs_ls, wait_fall;
  logic [15:0] s_rgb;
  logic [10:0] h_pos, h_cur;
  logic [9:0] v_pos, v_cur;
  logic ls, fs, win, err, pv, pulse;

  assign ls    = s_hs & ~p_hs;
  assign fs    = ls & s_vs & ~vs_ls;
  assign h_cur = ls ? 11'd0 : (&h_pos ? h_pos : h_pos + 11'd1);
  assign v_cur = !ls ? v_pos : fs ? 10'd0 : (&v_pos ? v_pos : v_pos + 10'd1);
  assign win   = h_cur >= X0 && h_cur < X1 && v_cur >= Y0 && v_cur < Y1;
  // Any of the five timing checks; ignored while still searching for a frame start
  assign err   = state != SEARCH &&
                 ((ls && h_pos != H_LAST) ||
                  (wait_fall && !s_hs && h_cur != H_SW) ||
                  h_cur == H_END ||
                  (fs && v_pos != V_LAST) ||
                  (ls && s_vs != (v_cur < V_SW)));

  always_ff @(posedge vga_clk or negedge sys_rst_n)
    if (!sys_rst_n) state <= SEARCH;
    else state <= nxt;

  always_comb nxt = err ? SEARCH : fs ? (state == SEARCH ? LOCKING : LOCKED) : state;

  always_comb begin
    locked = state == LOCKED;
    pv     = win && nxt == LOCKED;
    pulse  = fs && nxt == LOCKED;
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      s_hs        <= 1'b0;
      s_vs        <= 1'b0;
      s_rgb       <= '0;
      p_hs        <= 1'b0;
      vs_ls       <= 1'b0;
      wait_fall   <= 1'b0;
      h_pos       <= '0;
      v_pos       <= '0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_rgb     <= '0;
      pix_valid   <= 1'b0;
      frame_start <= 1'b0;
      err_cnt     <= '0;
      frame_cnt   <= '0;
    end else begin
      s_hs        <= hsync;
      s_vs        <= vsync;
      s_rgb       <= rgb;
      p_hs        <= s_hs;
      vs_ls       <= ls ? s_vs : vs_ls;
      wait_fall   <= ls | (wait_fall & s_hs);
      h_pos       <= h_cur;
      v_pos       <= v_cur;
      pix_x       <= pv ? 10'(h_cur - X0) : 10'd0;
      pix_y       <= pv ? v_cur - Y0 : 10'd0;
      pix_rgb     <= pv ? s_rgb : 16'd0;
      pix_valid   <= pv;
      frame_start <= pulse;
      err_cnt     <= (err && !(&err_cnt)) ? err_cnt + 8'd1 : err_cnt;
      frame_cnt   <= frame_cnt + 16'(pulse);
    end
endmodule

// File: tb/tb_vga_rx_monitor.sv
// tb_vga_rx_monitor: directed checks of vga_rx_monitor on a scaled-down 20x12 timing.
module tb_vga_rx_monitor;
  logic clk = 1'b0, sys_rst_n = 1'b0, hsync = 1'b0, vsync = 1'b0;
  logic [15:0] rgb = '0;
  logic [9:0] pix_x, pix_y;
  logic [15:0] pix_rgb, frame_cnt;
  logic pix_valid, frame_start, locked;
  logic [7:0] err_cnt;
  int n_cmp = 0, n_bad = 0, prev = -1, pulses = 0;

  always #5 clk = ~clk;

  // Active window: x in [8,16), y in [5,9); line 20 clocks, frame 12 lines
  vga_rx_monitor #(.H_SYNC(4), .H_BACK(3), .H_LEFT(1), .H_VALID(8), .H_TOTAL(20),
                   .V_SYNC(2), .V_BACK(2), .V_TOP(1), .V_VALID(4), .V_TOTAL(12)) dut (
    .vga_clk(clk), .sys_rst_n(sys_rst_n), .hsync(hsync), .vsync(vsync), .rgb(rgb),
    .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb), .pix_valid(pix_valid),
    .frame_start(frame_start), .locked(locked), .err_cnt(err_cnt), .frame_cnt(frame_cnt));

  typedef struct {
    int h; int v; logic [15:0] rgb;
    logic valid; int x; int y; logic [15:0] prgb;
  } vec_t;
  vec_t tab[8];

  initial forever begin
    @(negedge clk);
    if (frame_start) pulses++;
  end

  task automatic cmp(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_vec(input int i);
    cmp($sformatf("pix_valid[%0d]", i), int'(pix_valid), int'(tab[i].valid));
    cmp($sformatf("pix_x[%0d]", i), int'(pix_x), tab[i].x);
    cmp($sformatf("pix_y[%0d]", i), int'(pix_y), tab[i].y);
    cmp($sformatf("pix_rgb[%0d]", i), int'(pix_rgb), int'(tab[i].prgb));
  endtask

  // Outputs seen after this tick belong to the inputs of the previous tick
  task automatic tick(input logic hs, input logic vs, input logic [15:0] d, input int idx);
    hsync = hs; vsync = vs; rgb = d;
    @(posedge clk);
    @(negedge clk);
    if (prev >= 0) check_vec(prev);
    prev = idx;
  endtask

  task automatic line(input logic vs, input int hw, input int len, input int v, input bit chk);
    for (int h = 0; h < len; h++) begin
      int idx;
      logic [15:0] d;
      idx = -1;
      d = 16'h5A5A;
      if (chk) for (int i = 0; i < 8; i++)
        if (tab[i].h == h && tab[i].v == v) begin idx = i; d = tab[i].rgb; end
      tick(h < hw, vs, d, idx);
    end
  endtask

  task automatic frame(input int bad_v, input int bad_len, input int bad_hw, input int vs_lines, input bit chk);
    for (int v = 0; v < 12; v++)
      line(v < vs_lines, v == bad_v ? bad_hw : 4, v == bad_v ? bad_len : 20, v, chk);
  endtask

  initial begin
    tab[0] = '{8, 5, 16'hF800, 1'b1, 0, 0, 16'hF800};
    tab[1] = '{15, 8, 16'h07E0, 1'b1, 7, 3, 16'h07E0};
    tab[2] = '{16, 8, 16'h001F, 1'b0, 0, 0, 16'h0000};
    tab[3] = '{15, 9, 16'h1111, 1'b0, 0, 0, 16'h0000};
    tab[4] = '{7, 5, 16'h2222, 1'b0, 0, 0, 16'h0000};
    tab[5] = '{12, 6, 16'h1234, 1'b1, 4, 1, 16'h1234};
    tab[6] = '{8, 4, 16'h3333, 1'b0, 0, 0, 16'h0000};
    tab[7] = '{9, 7, 16'hABCD, 1'b1, 1, 2, 16'hABCD};
    hsync = 1'b1;
    repeat (3) @(negedge clk);
    cmp("rst pix_valid", int'(pix_valid), 0);
    cmp("rst pix_x", int'(pix_x), 0);
    cmp("rst pix_y", int'(pix_y), 0);
    cmp("rst pix_rgb", int'(pix_rgb), 0);
    cmp("rst locked", int'(locked), 0);
    cmp("rst err_cnt", int'(err_cnt), 0);
    cmp("rst frame_cnt", int'(frame_cnt), 0);
    sys_rst_n = 1'b1;
    frame(-1, 20, 4, 2, 0);
    cmp("locking locked", int'(locked), 0);
    frame(-1, 20, 4, 2, 0);
    cmp("lock locked", int'(locked), 1);
    cmp("lock frame_cnt", int'(frame_cnt), 1);
    cmp("lock pulses", pulses, 1);
    frame(-1, 20, 4, 2, 1);
    cmp("f3 frame_cnt", int'(frame_cnt), 2);
    cmp("f3 pulses", pulses, 2);
    frame(3, 21, 4, 2, 0);
    cmp("long line locked", int'(locked), 0);
    cmp("long line err_cnt", int'(err_cnt), 1);
    frame(-1, 20, 4, 2, 0);
    cmp("relock1 locked", int'(locked), 0);
    frame(-1, 20, 4, 2, 0);
    cmp("relock2 locked", int'(locked), 1);
    cmp("relock2 frame_cnt", int'(frame_cnt), 4);
    frame(3, 20, 3, 2, 0);
    cmp("short hs locked", int'(locked), 0);
    cmp("short hs err_cnt", int'(err_cnt), 2);
    frame(-1, 20, 4, 3, 0);
    cmp("long vs err_cnt", int'(err_cnt), 3);
    frame(-1, 20, 4, 2, 0);
    frame(-1, 20, 4, 2, 0);
    cmp("relock3 locked", int'(locked), 1);
    cmp("relock3 frame_cnt", int'(frame_cnt), 6);
    for (int i = 0; i < 60; i++) tick(1'b0, 1'b0, 16'h5A5A, -1);
    cmp("no hs err_cnt", int'(err_cnt), 4);
    cmp("no hs locked", int'(locked), 0);
    for (int i = 0; i < 250; i++) begin
      line(1'b1, 3, 20, -1, 0);
      line(1'b0, 4, 20, -1, 0);
    end
    cmp("err_cnt 254", int'(err_cnt), 254);
    for (int i = 0; i < 10; i++) begin
      line(1'b1, 3, 20, -1, 0);
      line(1'b0, 4, 20, -1, 0);
    end
    cmp("err_cnt sat", int'(err_cnt), 255);
    frame(-1, 20, 4, 2, 0);
    frame(-1, 20, 4, 2, 0);
    cmp("pre-reset locked", int'(locked), 1);
    for (int v = 0; v < 5; v++) line(v < 2, 4, 20, v, 0);
    #2 sys_rst_n = 1'b0;
    #1;
    cmp("mid rst locked", int'(locked), 0);
    cmp("mid rst err_cnt", int'(err_cnt), 0);
    cmp("mid rst frame_cnt", int'(frame_cnt), 0);
    cmp("mid rst pix_valid", int'(pix_valid), 0);
    hsync = 1'b1; vsync = 1'b1;
    repeat (2) @(negedge clk);
    sys_rst_n = 1'b1;
    frame(-1, 20, 4, 2, 0);
    frame(-1, 20, 4, 2, 0);
    cmp("post rst locked", int'(locked), 1);
    cmp("post rst frame_cnt", int'(frame_cnt), 1);
    cmp("post rst err_cnt", int'(err_cnt), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
